// File: rtl/mem_fill_responder.sv
// mem_fill_responder: fixed-latency, fully pipelined word memory responder for cache line fills
// Ports: clk; rst (async, active-low); enable/wr/addr/data_in form one request per cycle;
//        data_out/data_valid/data_addr present each read LAT cycles after accept; pending counts reads in flight.
module mem_fill_responder #(
    parameter int DEPTH_LOG = 10,
    parameter int LAT       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] data_addr,
    output logic [3:0]  pending
);
    logic [15:0] mem [0:(1<<DEPTH_LOG)-1];
    logic [LAT-1:0] v;
    logic [15:0] d [LAT];
    logic [15:0] a [LAT];
    logic rd;
    logic [DEPTH_LOG-1:0] idx;
    logic unused_addr_lsb;

    assign rd = enable & ~wr;
    assign idx = addr[DEPTH_LOG:1];
    assign unused_addr_lsb = addr[0];

    always_ff @(posedge clk)
        if (enable && wr) mem[idx] <= data_in;

    // Stage 0 captures the array word at the accept edge; the last stage drives the response.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v <= '0;
            for (int i = 0; i < LAT; i++) begin
                d[i] <= '0;
                a[i] <= '0;
            end
            pending <= '0;
        end else begin
            v[0] <= rd;
            d[0] <= rd ? mem[idx] : '0;
            a[0] <= rd ? {addr[15:1], 1'b0} : '0;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
                a[i] <= a[i-1];
            end
            pending <= pending + 4'(rd) - 4'(v[LAT-1]);
        end

    assign data_valid = v[LAT-1];
    assign data_out = d[LAT-1];
    assign data_addr = a[LAT-1];
endmodule
